// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_JALR_WAIT = 2'd1,
    S_MEM_WAIT  = 2'd2
  } state_t;

  localparam logic [6:0] JALR_OPCODE = 7'b1100111;
  localparam logic [2:0] JALR_FUNCT3 = 3'b000;

  // Stall cycles a JALR needs before forwarding can supply its rs1 operand
  localparam logic [1:0] JALR_LOAD_WAIT = 2'd2;
  localparam logic [1:0] JALR_ALU_WAIT  = 2'd1;

  function automatic logic is_jalr_insn(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == JALR_OPCODE) && (funct3 == JALR_FUNCT3);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - stall, bubble and flush sequencing for hazards forwarding cannot cover
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REGFILE_LEN     = 6,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REGFILE_LEN-1:0]     rs1_IF_ID,
  input  logic [REGFILE_LEN-1:0]     rs2_IF_ID,
  input  logic                       uses_rs1_IF_ID,
  input  logic                       uses_rs2_IF_ID,
  input  logic                       is_jalr_IF_ID,
  input  logic                       reg_write_ID_EX,
  input  logic                       mem_read_ID_EX,
  input  logic [REGFILE_LEN-1:0]     rd_ID_EX,
  input  logic                       reg_write_EX_MEM,
  input  logic                       mem_read_EX_MEM,
  input  logic [REGFILE_LEN-1:0]     rd_EX_MEM,
  input  logic                       branch_taken_EX,
  input  logic                       dmem_req_EX_MEM,
  input  logic                       dmem_ready,
  output logic                       stall_PC,
  output logic                       stall_IF_ID,
  output logic                       stall_ID_EX,
  output logic                       stall_EX_MEM,
  output logic                       bubble_ID_EX,
  output logic                       bubble_MEM_WB,
  output logic                       flush_IF_ID,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  state_t     state, state_n, ret_state, ret_state_n, eff_state;
  logic [1:0] jalr_cnt, jalr_cnt_n;
  logic [1:0] jalr_wait;
  logic       ex_rs1, ex_rs2, mem_rs1;
  logic       lu_hit, mem_hold, cnt_clear;

  // Producer matches ignore x0 and instructions that do not write back
  assign ex_rs1  = reg_write_ID_EX && (rd_ID_EX != '0) && (rs1_IF_ID == rd_ID_EX);
  assign ex_rs2  = reg_write_ID_EX && (rd_ID_EX != '0) && (rs2_IF_ID == rd_ID_EX);
  assign mem_rs1 = reg_write_EX_MEM && (rd_EX_MEM != '0) && (rs1_IF_ID == rd_EX_MEM);

  assign lu_hit   = mem_read_ID_EX && ((uses_rs1_IF_ID && ex_rs1) || (uses_rs2_IF_ID && ex_rs2));
  assign mem_hold = dmem_req_EX_MEM && !dmem_ready;

  // A released memory wait is judged by the state it interrupted
  assign eff_state = (state == S_MEM_WAIT) ? ret_state : state;

  // JALR resolves its target in ID, so rs1 must be ready earlier than for ALU users
  always_comb begin
    jalr_wait = 2'd0;
    if (is_jalr_IF_ID) begin
      if (ex_rs1 && mem_read_ID_EX) begin
        jalr_wait = JALR_LOAD_WAIT;
      end else if (ex_rs1 || (mem_rs1 && mem_read_EX_MEM)) begin
        jalr_wait = JALR_ALU_WAIT;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      ret_state <= S_RUN;
      jalr_cnt  <= 2'd0;
    end else begin
      state     <= state_n;
      ret_state <= ret_state_n;
      jalr_cnt  <= jalr_cnt_n;
    end
  end

  // Next state: memory hold freezes everything, a taken branch cancels pending waits
  always_comb begin
    state_n     = state;
    ret_state_n = ret_state;
    jalr_cnt_n  = jalr_cnt;
    if (mem_hold) begin
      if (state != S_MEM_WAIT) begin
        ret_state_n = state;
      end
      state_n = S_MEM_WAIT;
    end else if (branch_taken_EX) begin
      state_n    = S_RUN;
      jalr_cnt_n = 2'd0;
    end else if (eff_state == S_JALR_WAIT) begin
      jalr_cnt_n = jalr_cnt - 2'd1;
      state_n    = (jalr_cnt_n == 2'd0) ? S_RUN : S_JALR_WAIT;
    end else if (jalr_wait == JALR_LOAD_WAIT) begin
      jalr_cnt_n = JALR_LOAD_WAIT - 2'd1;
      state_n    = S_JALR_WAIT;
    end else begin
      state_n = S_RUN;
    end
  end

  // Pipeline controls, combinational with no added latency
  always_comb begin
    stall_PC      = 1'b0;
    stall_IF_ID   = 1'b0;
    stall_ID_EX   = 1'b0;
    stall_EX_MEM  = 1'b0;
    bubble_ID_EX  = 1'b0;
    bubble_MEM_WB = 1'b0;
    flush_IF_ID   = 1'b0;
    if (!rst_n) begin
      stall_PC = 1'b0;
    end else if (mem_hold) begin
      stall_PC      = 1'b1;
      stall_IF_ID   = 1'b1;
      stall_ID_EX   = 1'b1;
      stall_EX_MEM  = 1'b1;
      bubble_MEM_WB = 1'b1;
    end else if (branch_taken_EX) begin
      flush_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end else if ((eff_state == S_JALR_WAIT) || (jalr_wait != 2'd0) || lu_hit) begin
      stall_PC     = 1'b1;
      stall_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end
  end

  assign cnt_clear = !rst_n;

  sat_counter #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stall_counter (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (stall_PC),
    .count (stall_count)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_STL  = 7'b1100100;
  localparam logic [6:0] O_MEM  = 7'b1111010;
  localparam logic [6:0] O_BR   = 7'b0000101;

  typedef struct packed {
    logic [5:0] rs1;
    logic [5:0] rs2;
    logic       u1;
    logic       u2;
    logic       jalr;
    logic       rw_ex;
    logic       mr_ex;
    logic [5:0] rd_ex;
    logic       rw_mem;
    logic       mr_mem;
    logic [5:0] rd_mem;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  logic        clk, rst_n;
  logic [5:0]  rs1_IF_ID, rs2_IF_ID, rd_ID_EX, rd_EX_MEM;
  logic        uses_rs1_IF_ID, uses_rs2_IF_ID, is_jalr_IF_ID;
  logic        reg_write_ID_EX, mem_read_ID_EX, reg_write_EX_MEM, mem_read_EX_MEM;
  logic        branch_taken_EX, dmem_req_EX_MEM, dmem_ready;
  logic        stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic        bubble_ID_EX, bubble_MEM_WB, flush_IF_ID;
  logic [31:0] stall_count;
  logic        s_stall_PC, s_stall_IF_ID, s_stall_ID_EX, s_stall_EX_MEM;
  logic        s_bubble_ID_EX, s_bubble_MEM_WB, s_flush_IF_ID;
  logic [2:0]  s_stall_count;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;
  vec_t v[16];

  assign outs = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble_ID_EX, bubble_MEM_WB, flush_IF_ID};

  hazard_stall_controller dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .uses_rs1_IF_ID(uses_rs1_IF_ID), .uses_rs2_IF_ID(uses_rs2_IF_ID), .is_jalr_IF_ID(is_jalr_IF_ID),
    .reg_write_ID_EX(reg_write_ID_EX), .mem_read_ID_EX(mem_read_ID_EX), .rd_ID_EX(rd_ID_EX),
    .reg_write_EX_MEM(reg_write_EX_MEM), .mem_read_EX_MEM(mem_read_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
    .branch_taken_EX(branch_taken_EX), .dmem_req_EX_MEM(dmem_req_EX_MEM), .dmem_ready(dmem_ready),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM),
    .bubble_ID_EX(bubble_ID_EX), .bubble_MEM_WB(bubble_MEM_WB), .flush_IF_ID(flush_IF_ID),
    .stall_count(stall_count)
  );

  hazard_stall_controller #(.STALL_CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .uses_rs1_IF_ID(uses_rs1_IF_ID), .uses_rs2_IF_ID(uses_rs2_IF_ID), .is_jalr_IF_ID(is_jalr_IF_ID),
    .reg_write_ID_EX(reg_write_ID_EX), .mem_read_ID_EX(mem_read_ID_EX), .rd_ID_EX(rd_ID_EX),
    .reg_write_EX_MEM(reg_write_EX_MEM), .mem_read_EX_MEM(mem_read_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
    .branch_taken_EX(branch_taken_EX), .dmem_req_EX_MEM(dmem_req_EX_MEM), .dmem_ready(dmem_ready),
    .stall_PC(s_stall_PC), .stall_IF_ID(s_stall_IF_ID), .stall_ID_EX(s_stall_ID_EX), .stall_EX_MEM(s_stall_EX_MEM),
    .bubble_ID_EX(s_bubble_ID_EX), .bubble_MEM_WB(s_bubble_MEM_WB), .flush_IF_ID(s_flush_IF_ID),
    .stall_count(s_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [5:0] rs1, input logic [5:0] rs2, input logic u1, input logic u2,
                              input logic jalr, input logic rw_ex, input logic mr_ex, input logic [5:0] rd_ex,
                              input logic rw_mem, input logic mr_mem, input logic [5:0] rd_mem,
                              input logic br, input logic req, input logic rdy, input logic [6:0] exp);
    vec_t x;
    x = '{rs1, rs2, u1, u2, jalr, rw_ex, mr_ex, rd_ex, rw_mem, mr_mem, rd_mem, br, req, rdy, exp};
    return x;
  endfunction

  task automatic drive(input vec_t x);
    rs1_IF_ID = x.rs1;        rs2_IF_ID = x.rs2;
    uses_rs1_IF_ID = x.u1;    uses_rs2_IF_ID = x.u2;    is_jalr_IF_ID = x.jalr;
    reg_write_ID_EX = x.rw_ex; mem_read_ID_EX = x.mr_ex; rd_ID_EX = x.rd_ex;
    reg_write_EX_MEM = x.rw_mem; mem_read_EX_MEM = x.mr_mem; rd_EX_MEM = x.rd_mem;
    branch_taken_EX = x.br;   dmem_req_EX_MEM = x.req;  dmem_ready = x.rdy;
  endtask

  task automatic idle();
    drive(mk(6'd0, 6'd0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, O_NONE));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance one clock edge plus 1 time unit
  task automatic cyc(input string name, input logic [6:0] exp);
    @(negedge clk);
    check(name, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // IF_ID holds JALR rs1=7 while ID_EX holds a load to x7
  task automatic jalr_after_load();
    idle();
    is_jalr_IF_ID = 1'b1; rs1_IF_ID = 6'd7; uses_rs1_IF_ID = 1'b1;
    reg_write_ID_EX = 1'b1; mem_read_ID_EX = 1'b1; rd_ID_EX = 6'd7;
  endtask

  initial begin
    //       rs1    rs2   u1 u2 jr rwE mrE rdE   rwM mrM rdM   br rq rdy  exp
    v[0]  = mk(6'd0, 6'd0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, O_NONE);
    v[1]  = mk(6'd3, 6'd5, 1, 1, 0, 1, 1, 6'd5, 0, 0, 6'd0, 0, 0, 0, O_STL);
    v[2]  = mk(6'd3, 6'd5, 1, 0, 0, 1, 1, 6'd5, 0, 0, 6'd0, 0, 0, 0, O_NONE);
    v[3]  = mk(6'd0, 6'd2, 1, 1, 0, 1, 1, 6'd0, 0, 0, 6'd0, 0, 0, 0, O_NONE);
    v[4]  = mk(6'd5, 6'd1, 1, 1, 0, 0, 1, 6'd5, 0, 0, 6'd0, 0, 0, 0, O_NONE);
    v[5]  = mk(6'd3, 6'd5, 1, 1, 0, 1, 0, 6'd5, 0, 0, 6'd0, 0, 0, 0, O_NONE);
    v[6]  = mk(6'd7, 6'd0, 1, 0, 1, 1, 0, 6'd7, 0, 0, 6'd0, 0, 0, 0, O_STL);
    v[7]  = mk(6'd7, 6'd0, 1, 0, 1, 0, 0, 6'd0, 1, 1, 6'd7, 0, 0, 0, O_STL);
    v[8]  = mk(6'd7, 6'd0, 1, 0, 1, 0, 0, 6'd0, 1, 0, 6'd7, 0, 0, 0, O_NONE);
    v[9]  = mk(6'd0, 6'd0, 1, 0, 1, 1, 0, 6'd0, 1, 1, 6'd0, 0, 0, 0, O_NONE);
    v[10] = mk(6'd7, 6'd0, 1, 0, 1, 1, 1, 6'd7, 0, 0, 6'd0, 0, 0, 0, O_STL);
    v[11] = mk(6'd0, 6'd0, 0, 0, 0, 0, 0, 6'd0, 1, 1, 6'd4, 0, 1, 0, O_MEM);
    v[12] = mk(6'd0, 6'd0, 0, 0, 0, 0, 0, 6'd0, 1, 1, 6'd4, 0, 1, 1, O_NONE);
    v[13] = mk(6'd0, 6'd0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 6'd0, 1, 0, 0, O_BR);
    v[14] = mk(6'd3, 6'd5, 1, 1, 0, 1, 1, 6'd5, 0, 0, 6'd0, 1, 0, 0, O_BR);
    v[15] = mk(6'd3, 6'd5, 1, 1, 1, 1, 1, 6'd5, 0, 0, 6'd0, 1, 1, 0, O_MEM);

    // Reset with a memory hold and load-use present: outputs forced low
    rst_n = 1'b0;
    drive(v[15]);
    #1;
    @(negedge clk);
    check("reset_outs", 32'(outs), 32'(O_NONE));
    @(posedge clk);
    #1;
    check("reset_count", stall_count, 32'd0);
    check("reset_count_small", 32'(s_stall_count), 32'd0);

    // Single-cycle vectors, each started from a fresh reset
    for (int i = 0; i < 16; i++) begin
      drive(v[i]);
      rst_n = 1'b1;
      cyc($sformatf("vec%0d_outs", i), v[i].exp);
      check($sformatf("vec%0d_count", i), stall_count, v[i].exp[6] ? 32'd1 : 32'd0);
      do_reset();
    end

    // Load-use: one stall, then the load moves to EX_MEM and forwarding takes over
    idle();
    rs2_IF_ID = 6'd5; uses_rs2_IF_ID = 1'b1;
    reg_write_ID_EX = 1'b1; mem_read_ID_EX = 1'b1; rd_ID_EX = 6'd5;
    cyc("lu_c1", O_STL);
    reg_write_ID_EX = 1'b0; mem_read_ID_EX = 1'b0; rd_ID_EX = 6'd0;
    reg_write_EX_MEM = 1'b1; mem_read_EX_MEM = 1'b1; rd_EX_MEM = 6'd5;
    cyc("lu_c2", O_NONE);
    check("lu_count", stall_count, 32'd1);
    do_reset();

    // JALR after load: two stall cycles
    jalr_after_load();
    cyc("jl_c1", O_STL);
    reg_write_ID_EX = 1'b0; mem_read_ID_EX = 1'b0; rd_ID_EX = 6'd0;
    reg_write_EX_MEM = 1'b1; mem_read_EX_MEM = 1'b1; rd_EX_MEM = 6'd7;
    cyc("jl_c2", O_STL);
    reg_write_EX_MEM = 1'b0; mem_read_EX_MEM = 1'b0; rd_EX_MEM = 6'd0;
    cyc("jl_c3", O_NONE);
    check("jl_count", stall_count, 32'd2);
    do_reset();

    // JALR after ALU op: one stall, then forwarding from EX_MEM
    idle();
    is_jalr_IF_ID = 1'b1; rs1_IF_ID = 6'd7;
    reg_write_ID_EX = 1'b1; rd_ID_EX = 6'd7;
    cyc("ja_c1", O_STL);
    reg_write_ID_EX = 1'b0; rd_ID_EX = 6'd0;
    reg_write_EX_MEM = 1'b1; rd_EX_MEM = 6'd7;
    cyc("ja_c2", O_NONE);
    check("ja_count", stall_count, 32'd1);
    do_reset();

    // Memory wait inside a JALR wait: 3 frozen cycles, then the remaining JALR stall
    jalr_after_load();
    cyc("mw_c1", O_STL);
    reg_write_ID_EX = 1'b0; mem_read_ID_EX = 1'b0; rd_ID_EX = 6'd0;
    reg_write_EX_MEM = 1'b1; mem_read_EX_MEM = 1'b1; rd_EX_MEM = 6'd9;
    dmem_req_EX_MEM = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc($sformatf("mw_hold%0d", k), O_MEM);
    dmem_ready = 1'b1;
    cyc("mw_release", O_STL);
    dmem_req_EX_MEM = 1'b0; dmem_ready = 1'b0;
    reg_write_EX_MEM = 1'b0; mem_read_EX_MEM = 1'b0; rd_EX_MEM = 6'd0;
    cyc("mw_after", O_NONE);
    check("mw_count", stall_count, 32'd5);
    do_reset();

    // Taken branch cancels a pending JALR wait
    jalr_after_load();
    cyc("bj_c1", O_STL);
    reg_write_ID_EX = 1'b0; mem_read_ID_EX = 1'b0; rd_ID_EX = 6'd0;
    branch_taken_EX = 1'b1;
    cyc("bj_c2", O_BR);
    branch_taken_EX = 1'b0;
    cyc("bj_c3", O_NONE);
    check("bj_count", stall_count, 32'd1);
    do_reset();

    // Reset in the middle of a JALR wait
    jalr_after_load();
    cyc("rj_c1", O_STL);
    reg_write_ID_EX = 1'b0; mem_read_ID_EX = 1'b0; rd_ID_EX = 6'd0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rj_reset_outs", 32'(outs), 32'(O_NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rj_count", stall_count, 32'd0);
    check("rj_count_small", 32'(s_stall_count), 32'd0);
    cyc("rj_after", O_NONE);

    // Held load-use stall: narrow counter saturates, wide one keeps counting
    idle();
    rs2_IF_ID = 6'd5; uses_rs2_IF_ID = 1'b1;
    reg_write_ID_EX = 1'b1; mem_read_ID_EX = 1'b1; rd_ID_EX = 6'd5;
    for (int k = 0; k < 10; k++) begin
      cyc($sformatf("sat_c%0d", k), O_STL);
      check($sformatf("sat_count%0d", k), stall_count, 32'(k + 1));
      check($sformatf("sat_small%0d", k), 32'(s_stall_count), (k < 7) ? 32'(k + 1) : 32'd7);
    end
    branch_taken_EX = 1'b1;
    cyc("sat_flush", O_BR);
    check("sat_flush_count", stall_count, 32'd10);
    check("sat_flush_small", 32'(s_stall_count), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences pipeline stalls, bubbles and flushes around the forwarding unit.
- Covers the hazards forwarding cannot cover: load-use, JALR target-operand waits, data-memory wait states and taken-branch flush.
- Sits in core/pipeline/hazard beside the forwarding unit.
- Drives the enable and clear controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.

Parameters:
- REGFILE_LEN, 6: register-index width.
- STALL_CNT_WIDTH, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rs1_IF_ID  in  REGFILE_LEN  rs1 of decoding instruction
- rs2_IF_ID  in  REGFILE_LEN  rs2 of decoding instruction
- uses_rs1_IF_ID  in  1  decoding instruction reads rs1
- uses_rs2_IF_ID  in  1  decoding instruction reads rs2
- is_jalr_IF_ID  in  1  decoding instruction is JALR (opcode 1100111, funct3 000)
- reg_write_ID_EX  in  1  ID_EX instruction writes a register
- mem_read_ID_EX  in  1  ID_EX instruction is a load
- rd_ID_EX  in  REGFILE_LEN  ID_EX destination
- reg_write_EX_MEM  in  1  EX_MEM instruction writes a register
- mem_read_EX_MEM  in  1  EX_MEM instruction is a load
- rd_EX_MEM  in  REGFILE_LEN  EX_MEM destination
- branch_taken_EX  in  1  branch/JAL resolved taken in EX
- dmem_req_EX_MEM  in  1  data-memory access active in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- stall_PC  out  1  hold PC
- stall_IF_ID  out  1  hold IF_ID
- stall_ID_EX  out  1  hold ID_EX
- stall_EX_MEM  out  1  hold EX_MEM
- bubble_ID_EX  out  1  load NOP into ID_EX
- bubble_MEM_WB  out  1  load NOP into MEM_WB
- flush_IF_ID  out  1  clear IF_ID
- stall_count  out  STALL_CNT_WIDTH  saturating count of cycles with stall_PC=1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=S_RUN, jalr_cnt=0, ret_state=S_RUN, stall_count=0.
  - While rst_n=0, all control outputs are forced to 0.
- Terms. All producer matches require reg_write=1 and rd≠0.
  - lu_hit (load-use): mem_read_ID_EX and rd_ID_EX matches rs1_IF_ID (with uses_rs1) or rs2_IF_ID (with uses_rs2).
  - jalr_wait, evaluated only when is_jalr_IF_ID=1, using rs1_IF_ID:
    - = 2 if it matches rd_ID_EX and mem_read_ID_EX.
    - = 1 if it matches rd_ID_EX without a load, or matches rd_EX_MEM with mem_read_EX_MEM.
    - = 0 otherwise.
  - mem_hold = dmem_req_EX_MEM & ~dmem_ready.
- States: S_RUN, S_JALR_WAIT, S_MEM_WAIT.
- Priority, highest first: mem_hold, branch_taken_EX, JALR wait / load-use.
- mem_hold, from any state:
  - Outputs: stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble_MEM_WB = 1; all other outputs 0.
  - Transition: if not already in S_MEM_WAIT, ret_state <= current state; state <= S_MEM_WAIT.
  - jalr_cnt is frozen.
- S_MEM_WAIT:
  - Leaves when mem_hold=0, on the same cycle dmem_ready=1.
  - That cycle is evaluated with ret_state's rules; next state follows from ret_state.
  - No extra bubble on the release cycle.
- branch_taken_EX, without mem_hold:
  - Outputs: flush_IF_ID=1, bubble_ID_EX=1, no stalls.
  - Cancels any pending load-use or JALR wait: state <= S_RUN, jalr_cnt <= 0.
- S_RUN, JALR case (jalr_wait>0): stall_PC, stall_IF_ID, bubble_ID_EX = 1.
  - If jalr_wait=2: jalr_cnt <= 1, state <= S_JALR_WAIT.
  - Total stall = jalr_wait cycles; afterwards the forwarding unit supplies the JALR operand.
- S_RUN, load-use (lu_hit=1, no JALR wait): exactly 1 cycle of stall_PC, stall_IF_ID, bubble_ID_EX = 1; remain in S_RUN.
- S_JALR_WAIT: stall_PC, stall_IF_ID, bubble_ID_EX = 1; jalr_cnt decrements; state <= S_RUN when jalr_cnt reaches 0.
- Control outputs are combinational from state and inputs; zero added latency.
- stall_count:
  - +1 on each clk edge where stall_PC=1.
  - Saturates at all-ones; no wrap.
  - Holds its value under flush.

Decomposition:
- hazard_pkg:
  - State encoding S_RUN / S_JALR_WAIT / S_MEM_WAIT, 2 bits.
  - JALR opcode/funct3 constants.
  - JALR_LOAD_WAIT=2, JALR_ALU_WAIT=1.
- Sub-module sat_counter (parameter WIDTH; inputs inc and synchronous clear) implements stall_count.

Test Plan:
- Load-use: ID_EX is lw rd=5; IF_ID is add with rs2=5 (uses_rs2=1). Expect one cycle of stall_PC=stall_IF_ID=bubble_ID_EX=1, then all 0; stall_count=1.
- JALR after load: ID_EX lw rd=7; IF_ID JALR rs1=7. Expect 2 stall cycles (S_RUN, then S_JALR_WAIT), then S_RUN; stall_count=2.
- JALR after ALU op (rd_ID_EX=7, no load): 1 stall cycle. Case with rs1=0 and rd=0: 0 stall cycles.
- Memory wait inside a JALR wait: mem_hold rises during S_JALR_WAIT for 3 cycles. Expect full freeze, jalr_cnt held, bubble_MEM_WB=1 for 3 cycles; then 1 remaining JALR stall cycle; stall_count=5.
- Branch during load-use: lu_hit=1 and branch_taken_EX=1 in the same cycle. Expect flush_IF_ID=bubble_ID_EX=1, stall_PC=0, state S_RUN.
- Reset mid-S_JALR_WAIT (rst_n=0 for one edge): state S_RUN, stall_count=0, all outputs 0. Also force the counter to all-ones and hold a stall: expect it to stay all-ones.
